// File: rtl/result_drain_if.sv
// rtl/result_drain_if.sv - valid/ready result stream carrying one C element per beat
interface result_drain_if #(
   parameter int N  = 4,
   parameter int DW = 32
);
   localparam int RW = (N > 1) ? $clog2(N) : 1;

   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic [RW-1:0] m_row;
   logic [RW-1:0] m_col;
   logic          m_last;

   modport master (
      output m_valid,
      output m_data,
      output m_row,
      output m_col,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      input  m_row,
      input  m_col,
      input  m_last,
      output m_ready
   );
endinterface

// File: rtl/result_drain.sv
// rtl/result_drain.sv - snapshots the systolic C array on done and streams it out row-major
module result_drain #(
   parameter int N  = 4,
   parameter int DW = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                capture,
   input  logic [N*N*DW-1:0]   c_flat,
   result_drain_if.master      m,
   output logic                busy,
   output logic                overrun,
   input  logic                clr_overrun
);
   localparam int NE = N * N;
   localparam int IW = (NE > 1) ? $clog2(NE) : 1;
   localparam int RW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [NE*DW-1:0] shadow_q, shadow_d;
   logic             overrun_q, overrun_d;

   // Everything downstream sees is derived from registered state, so m_ready
   // only ever reaches the next-state logic and never an output.
   logic last_idx;
   logic xfer;
   assign last_idx = (idx_q == IW'(NE - 1));
   assign xfer     = (state_q == STREAM) && m.m_ready;

   // State register: synchronous active-low reset abandons any snapshot.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         shadow_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         shadow_q  <= shadow_d;
         overrun_q <= overrun_d;
      end
   end

   // Next state: accept capture when idle or on the final transfer, else flag overrun.
   always_comb begin
      logic ovr_evt;
      state_d  = state_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      ovr_evt  = 1'b0;
      case (state_q)
         IDLE: begin
            if (capture) begin
               shadow_d = c_flat;
               idx_d    = '0;
               state_d  = STREAM;
            end
         end
         STREAM: begin
            if (xfer && last_idx) begin
               idx_d = '0;
               if (capture) begin
                  // Back-to-back matrix: reload and keep streaming with no bubble.
                  shadow_d = c_flat;
                  state_d  = STREAM;
               end else begin
                  state_d  = IDLE;
               end
            end else begin
               if (xfer) begin
                  idx_d = idx_q + IW'(1);
               end
               ovr_evt = capture;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
      // A coincident new overrun event outranks the clear.
      overrun_d = (overrun_q && !clr_overrun) || ovr_evt;
   end

   // Outputs: present the indexed shadow element while streaming, zeros when idle.
   always_comb begin
      m.m_valid = 1'b0;
      m.m_data  = '0;
      m.m_row   = '0;
      m.m_col   = '0;
      m.m_last  = 1'b0;
      busy      = 1'b0;
      if (state_q == STREAM) begin
         m.m_valid = 1'b1;
         busy      = 1'b1;
         m.m_data  = shadow_q[idx_q*DW +: DW];
         m.m_row   = RW'(idx_q / IW'(N));
         m.m_col   = RW'(idx_q % IW'(N));
         m.m_last  = last_idx;
      end
   end

   assign overrun = overrun_q;
endmodule
